// File: rtl/spi_master_gen.sv
// SPI master: all four CPOL/CPHA modes, configurable word width and bit order,
// multiple chip selects and CS-held bursts. Every flop runs on sys_clk; sclk is a registered output.
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 1,
  parameter int CS_W   = 3
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, WAIT, GAP} state_t;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  hcnt_q, hcnt_d, div_q, div_d, hcnt_inc;
  logic [EW-1:0]     ecnt_q, ecnt_d;
  logic              setup_q, setup_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d, rx_pend_q, rx_pend_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_nxt;
  logic              last_q, last_d, cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic              hdone, sample_e, final_e;

  assign hdone    = (hcnt_q == div_q);
  assign hcnt_inc = hdone ? '0 : hcnt_q + DIV_W'(1);
  // Edge k (1-based) is ecnt_q+1: cpha=0 samples odd edges, cpha=1 samples even edges.
  assign sample_e = (ecnt_q[0] == cpha_q);
  assign final_e  = (ecnt_q == EW'(EDGES - 1));
  assign tx_nxt   = tx_shift(tx_sh_q, lsb_q);

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    ecnt_d     = ecnt_q;
    setup_d    = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_pend_d  = 1'b0;
    rx_data_d  = rx_data_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    last_d     = last_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    div_d      = div_q;

    if (rx_pend_q) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_sh_q;
    end

    case (state_q)
      IDLE: begin
        sclk_d     = cpol;
        hcnt_d     = '0;
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_d      = lsb_first;
          div_d      = clk_div;
          last_d     = tx_last;
          tx_sh_d    = tx_data;
          mosi_d     = first_bit(tx_data, lsb_first);
          for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (cs_sel != CS_W'(i));
          ecnt_d     = '0;
          setup_d    = 1'b1;
          tx_ready_d = 1'b0;
          state_d    = LEAD;
        end
      end
      // One setup cycle after the handshake, then a full half period of lead time.
      LEAD: begin
        if (!setup_q) begin
          hcnt_d = hcnt_inc;
          if (hdone) state_d = XFER;
        end
      end
      XFER: begin
        hcnt_d = hcnt_inc;
        if (hdone) begin
          sclk_d = ~sclk_q;
          ecnt_d = ecnt_q + EW'(1);
          if (sample_e) begin
            rx_sh_d = rx_shift(rx_sh_q, miso, lsb_q);
          end else if (ecnt_q != '0 && !final_e) begin
            tx_sh_d = tx_nxt;
            mosi_d  = first_bit(tx_nxt, lsb_q);
          end
          if (final_e) begin
            rx_pend_d = 1'b1;
            state_d   = last_q ? TRAIL : WAIT;
          end
        end
      end
      WAIT: begin
        if (tx_valid && tx_ready_q) begin
          last_d  = tx_last;
          tx_sh_d = tx_data;
          mosi_d  = first_bit(tx_data, lsb_q);
          ecnt_d  = '0;
          hcnt_d  = '0;
          state_d = XFER;
        end else if (hdone) begin
          tx_ready_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + DIV_W'(1);
        end
      end
      TRAIL: begin
        hcnt_d = hcnt_inc;
        if (hdone) begin
          cs_n_d  = '1;
          state_d = GAP;
        end
      end
      GAP: begin
        hcnt_d = hcnt_inc;
        if (hdone) begin
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      ecnt_q     <= '0;
      setup_q    <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      ecnt_q     <= ecnt_d;
      setup_q    <= setup_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_pend_q  <= rx_pend_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      div_q      <= div_d;
    end
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised, single-clock-domain SPI master. It supersedes the fixed 8-bit, single-CS, shared-data-line master. It supports all four CPOL/CPHA modes, configurable word width and bit order, multiple chip selects, separate MOSI/MISO lines, and multi-word bursts with CS held low. It sits between a register/DMA front end (valid/ready word stream) and external SPI peripherals (RTC, flash, sensors).

Parameters:
DATA_W, 8, bits per SPI word (2..32)
DIV_W, 8, width of clk_div
NUM_CS, 1, number of chip-select outputs (1..8)
CS_W, 3, width of cs_sel (must satisfy 2**CS_W >= NUM_CS)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
cpol  in  1  SCLK idle level; latched at frame start
cpha  in  1  0: sample on leading edge, 1: sample on trailing edge; latched at frame start
lsb_first  in  1  bit order; latched at frame start
clk_div  in  DIV_W  SCLK half period H = clk_div+1 sys_clk cycles; latched at frame start
cs_sel  in  CS_W  chip-select index; latched at frame start
tx_valid  in  1  word available
tx_ready  out  1  master can accept a word
tx_data  in  DATA_W  word to send
tx_last  in  1  with accepted word: release CS after this word
rx_valid  out  1  one-cycle pulse, rx_data updated
rx_data  out  DATA_W  last received word
busy  out  1  high whenever state != IDLE
sclk  out  1  SPI clock (registered)
mosi  out  1  SPI data out (registered)
miso  in  1  SPI data in
cs_n  out  NUM_CS  active-low selects (registered)

Behaviour:
- Reset (rst=1 at a sys_clk edge) values: state=IDLE, sclk=0, mosi=0, cs_n=all 1, tx_ready=0, rx_valid=0, rx_data=0, busy=0, latched config=0. Reset mid-frame aborts immediately; no rx_valid is produced.
- States: IDLE, LEAD, XFER, TRAIL, WAIT, GAP.
- IDLE: tx_ready=1, sclk tracks cpol (registered). On tx_valid&tx_ready: latch tx_data/tx_last/config, drive cs_n[cs_sel]=0 and mosi=first bit (MSB, or LSB if lsb_first) on the next cycle, then go to LEAD. If cs_sel>=NUM_CS, no CS is asserted but the transfer still runs.
- LEAD: hold for H cycles, then XFER.
- XFER: 2*DATA_W SCLK edges, one every H cycles; sclk toggles from cpol.
  - cpha=0: sample miso on odd edges (1,3,..); shift mosi on even edges except the last.
  - cpha=1: shift mosi on odd edges (first bit on edge 1); sample on even edges.
  - Sampling captures the miso value present in the sys_clk cycle on which the sclk register toggles. Received bits assemble in the same order as transmitted.
  - After the final edge, sclk=cpol. The next cycle pulses rx_valid with rx_data updated.
- After XFER:
  - If the word was last: go to TRAIL.
  - Otherwise: go to WAIT.
- WAIT: CS stays low, sclk=cpol, tx_ready=1. Hold for at least H cycles. On a handshake after that: load the word, drive the first mosi bit, go to XFER. If tx_valid stays low, WAIT holds indefinitely. Config inputs are ignored mid-frame.
- TRAIL: hold for H cycles, then deassert all cs_n and go to GAP.
- GAP: CS high for H cycles (minimum deselect time), then IDLE. tx_ready=0 in LEAD, XFER, TRAIL, GAP.
- Timing: one word occupies 2*DATA_W*H cycles in XFER. A single-word frame takes 1 + H (lead) + 2*DATA_W*H + H (trail) + H (gap) cycles from handshake to IDLE.
- Counters: the half-period counter is DIV_W bits and compares to the latched clk_div; clk_div=0 gives H=1 (SCLK = sys_clk/2). The edge counter is ceil(log2(2*DATA_W+1)) bits.
- No derived clocks: sclk is a data output only; all flops run on sys_clk.

Test Plan:
- DATA_W=8, cpol=0, cpha=0, clk_div=1, msb first, tx_data=8'hA5, miso fed 8'h3C, tx_last=1 -> mosi bits 1,0,1,0,0,1,0,1 stable across each rising sclk; 8 rising edges; rx_valid pulse once with rx_data=8'h3C; cs_n low 1+2+32+2 cycles; busy low after gap.
- Repeat for modes (cpol,cpha)=(0,1),(1,0),(1,1) with 8'hC3 loopback (miso=mosi) -> rx_data=8'hC3 in each mode; idle sclk equals cpol before and after the frame.
- lsb_first=1, DATA_W=12, tx_data=12'h801, loopback -> first mosi bit 1, last bit 1, rx_data=12'h801.
- Burst of 3 words (11,22,33, tx_last on third) with tx_valid gapped 20 cycles before word 2 -> cs_n stays low throughout; sclk idle during the stall; three rx_valid pulses; CS released only after word 3.
- NUM_CS=4, cs_sel=2 -> only cs_n[2] toggles. cs_sel=5 (CS_W=3) -> no cs_n asserted, rx_valid still pulses.
- rst asserted at edge 5 of a word -> next cycle: cs_n all 1, sclk=0, busy=0, no rx_valid. A new transfer afterwards completes normally.
